alu_issue: RTL and testbench

Instruction-side driver for the 4-bit-op ALU. It accepts RV32I OP and OP-IMM instructions over a valid/ready handshake, reads operands from an internal 32×32 register file, and issues one ALU operation. It captures the ALU result and flags, then writes back. It sits between the fetch stage and the ALU and owns the architectural integer registers for the ALU datapath.

---
 rtl/alu_issue.sv | 144 ++++++++++++++
 tb/tb_alu_issue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue stage for the 4-bit-op ALU: decodes RV32I OP/OP-IMM, reads the register file,
// drives the ALU for one cycle and writes the captured result back to the register file.
module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    output logic [31:0] alu_lhs,
    output logic [31:0] alu_rhs,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_res,
    input  logic [3:0]  alu_flags,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_flags,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, WB, ERR} state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    state_t      state_q, state_d;
    logic [31:0] rf_q [32];
    logic [31:0] alu_lhs_q, alu_rhs_q, wb_data_q;
    logic [3:0]  alu_op_q, wb_flags_q;
    logic [4:0]  rd_q, wb_rd_q;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_val, rs2_val, dec_rhs;
    logic [3:0]  dec_op;
    logic        dec_legal, accept;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf_q[dbg_addr];

    // funct3 doubles as the low three op bits; the alternate funct7 sets op[3].
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = 4'b0000;
        dec_rhs   = rs2_val;
        unique case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    dec_legal = 1'b1;
                    dec_op    = {1'b0, funct3};
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec_legal = 1'b1;
                    dec_op    = {1'b1, 2'b00, funct3[2]};
                end
            end
            OPC_OP_IMM: begin
                unique case (funct3)
                    3'b001: begin
                        dec_legal = (funct7 == F7_BASE);
                        dec_op    = 4'b0001;
                        dec_rhs   = {27'd0, inst[24:20]};
                    end
                    3'b101: begin
                        dec_legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                        dec_op    = (funct7 == F7_ALT) ? 4'b1001 : 4'b0101;
                        dec_rhs   = {27'd0, inst[24:20]};
                    end
                    default: begin
                        dec_legal = 1'b1;
                        dec_op    = {1'b0, funct3};
                        dec_rhs   = {{20{inst[31]}}, inst[31:20]};
                    end
                endcase
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign inst_ready = rst_n && (state_q == IDLE);
    assign accept     = inst_valid && inst_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = dec_legal ? ISSUE : ERR;
            ISSUE:   state_d = WB;
            WB:      state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_lhs_q  <= '0;
            alu_rhs_q  <= '0;
            alu_op_q   <= '0;
            rd_q       <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_flags_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept && dec_legal) begin
                alu_lhs_q <= rs1_val;
                alu_rhs_q <= dec_rhs;
                alu_op_q  <= dec_op;
                rd_q      <= rd;
            end
            // ALU settles on the falling edge, so its result is stable here.
            if (state_q == ISSUE) begin
                wb_data_q  <= alu_res;
                wb_flags_q <= alu_flags;
                wb_rd_q    <= rd_q;
            end
            if (state_q == WB && wb_rd_q != 5'd0) rf_q[wb_rd_q] <= wb_data_q;
        end
    end

    assign alu_lhs  = alu_lhs_q;
    assign alu_rhs  = alu_rhs_q;
    assign alu_op   = alu_op_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign wb_flags = wb_flags_q;
    assign wb_valid = rst_n && (state_q == WB);
    assign illegal  = rst_n && (state_q == ERR);

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: behavioural ALU on the falling edge, expected
// writebacks queued at issue time and compared when wb_valid fires.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [31:0] inst = '0;
    logic [31:0] alu_lhs, alu_rhs;
    logic [3:0]  alu_op;
    logic [31:0] alu_res = '0;
    logic [3:0]  alu_flags = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [3:0]  wb_flags;
    logic        illegal;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [3:0]  flags;
        logic [3:0]  op;
        logic [31:0] lhs;
        logic [31:0] rhs;
    } exp_t;
    exp_t        sbq[$];
    logic [31:0] exp_rf [32];

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_op(alu_op),
        .alu_res(alu_res), .alu_flags(alu_flags), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_flags(wb_flags), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: {is_zero, sign, carry, overflow}; carry/overflow only for add/sub.
    always @(negedge clk) begin
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (alu_op)
            4'b0000: begin s = {1'b0, alu_lhs} + {1'b0, alu_rhs}; r = s[31:0]; c = s[32];
                           v = (alu_lhs[31] == alu_rhs[31]) && (r[31] != alu_lhs[31]); end
            4'b1000: begin s = {1'b0, alu_lhs} + {1'b0, ~alu_rhs} + 33'd1; r = s[31:0]; c = s[32];
                           v = (alu_lhs[31] != alu_rhs[31]) && (r[31] != alu_lhs[31]); end
            4'b0001: r = alu_lhs << alu_rhs[4:0];
            4'b0010: r = {31'd0, $signed(alu_lhs) < $signed(alu_rhs)};
            4'b0011: r = {31'd0, alu_lhs < alu_rhs};
            4'b0100: r = alu_lhs ^ alu_rhs;
            4'b0101: r = alu_lhs >> alu_rhs[4:0];
            4'b0110: r = alu_lhs | alu_rhs;
            4'b0111: r = alu_lhs & alu_rhs;
            4'b1001: r = $unsigned($signed(alu_lhs) >>> alu_rhs[4:0]);
            default: r = '0;
        endcase
        alu_res   <= r;
        alu_flags <= {r == 32'd0, r[31], c, v};
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic expect_wb(input logic [4:0] rd, input logic [31:0] data, input logic [3:0] flags,
                             input logic [3:0] op, input logic [31:0] lhs, input logic [31:0] rhs);
        exp_t e;
        e.rd = rd; e.data = data; e.flags = flags; e.op = op; e.lhs = lhs; e.rhs = rhs;
        sbq.push_back(e);
        if (rd != 5'd0) exp_rf[rd] = data;
    endtask

    // Drives one instruction and checks the cycle-by-cycle handshake timing.
    task automatic send(input logic [31:0] w, input bit legal);
        int n = 0;
        while (!inst_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk("ready_wait", {31'd0, inst_ready}, 32'd1);
        inst = w; inst_valid = 1'b1;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        chk("c1_ready", {31'd0, inst_ready}, 32'd0);
        chk("c1_wb", {31'd0, wb_valid}, 32'd0);
        if (legal) begin
            chk("c1_illegal", {31'd0, illegal}, 32'd0);
            @(posedge clk); #1;
            chk("c2_wb", {31'd0, wb_valid}, 32'd1);
            @(posedge clk); #1;
            chk("c3_ready", {31'd0, inst_ready}, 32'd1);
        end else begin
            chk("c1_illegal", {31'd0, illegal}, 32'd1);
            @(posedge clk); #1;
            chk("c2_illegal", {31'd0, illegal}, 32'd0);
            chk("c2_ready", {31'd0, inst_ready}, 32'd1);
        end
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = i[4:0];
            #1;
            chk(tag, dbg_data, exp_rf[i]);
        end
    endtask

    // Writeback monitor: every wb_valid must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (wb_valid) begin
            if (sbq.size() == 0) begin
                chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_data", wb_data, e.data);
                chk("wb_flags", {28'd0, wb_flags}, {28'd0, e.flags});
                chk("alu_op", {28'd0, alu_op}, {28'd0, e.op});
                chk("alu_lhs", alu_lhs, e.lhs);
                chk("alu_rhs", alu_rhs, e.rhs);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 32; i++) exp_rf[i] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, inst_ready}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_lhs", alu_lhs, 32'd0);
        chk("rst_rhs", alu_rhs, 32'd0);
        chk("rst_op", {28'd0, alu_op}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_flags", {28'd0, wb_flags}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", {31'd0, inst_ready}, 32'd1);

        // addi x1,x0,-5
        expect_wb(5'd1, 32'hFFFF_FFFB, 4'b0100, 4'b0000, 32'd0, 32'hFFFF_FFFB);
        send(32'hFFB0_0093, 1'b1);
        dbg_addr = 5'd1; #1;
        chk("dbg_x1", dbg_data, 32'hFFFF_FFFB);

        // Dependent back-to-back shifts
        expect_wb(5'd2, 32'hFFFF_FFFD, 4'b0100, 4'b1001, 32'hFFFF_FFFB, 32'd1);
        send(enc_i(12'h401, 5'd1, 3'b101, 5'd2), 1'b1);
        expect_wb(5'd3, 32'h7FFF_FFFD, 4'b0000, 4'b0101, 32'hFFFF_FFFB, 32'd1);
        send(enc_i(12'h001, 5'd1, 3'b101, 5'd3), 1'b1);

        // R-type with x4=5, x5=7
        expect_wb(5'd4, 32'd5, 4'b0000, 4'b0000, 32'd0, 32'd5);
        send(enc_i(12'd5, 5'd0, 3'b000, 5'd4), 1'b1);
        expect_wb(5'd5, 32'd7, 4'b0000, 4'b0000, 32'd0, 32'd7);
        send(enc_i(12'd7, 5'd0, 3'b000, 5'd5), 1'b1);
        expect_wb(5'd6, 32'hFFFF_FFFE, 4'b0100, 4'b1000, 32'd5, 32'd7);
        send(enc_r(7'b0100000, 5'd5, 5'd4, 3'b000, 5'd6), 1'b1);
        expect_wb(5'd7, 32'd1, 4'b0000, 4'b0010, 32'd5, 32'd7);
        send(enc_r(7'b0000000, 5'd5, 5'd4, 3'b010, 5'd7), 1'b1);
        expect_wb(5'd8, 32'd1, 4'b0000, 4'b0011, 32'd5, 32'd7);
        send(enc_r(7'b0000000, 5'd5, 5'd4, 3'b011, 5'd8), 1'b1);
        expect_wb(5'd9, 32'd2, 4'b0000, 4'b0100, 32'd5, 32'd7);
        send(enc_r(7'b0000000, 5'd5, 5'd4, 3'b100, 5'd9), 1'b1);
        expect_wb(5'd10, 32'd7, 4'b0000, 4'b0110, 32'd5, 32'd7);
        send(enc_r(7'b0000000, 5'd5, 5'd4, 3'b110, 5'd10), 1'b1);
        expect_wb(5'd11, 32'd5, 4'b0000, 4'b0111, 32'd5, 32'd7);
        send(enc_r(7'b0000000, 5'd5, 5'd4, 3'b111, 5'd11), 1'b1);
        expect_wb(5'd12, 32'h0000_00E0, 4'b0000, 4'b0001, 32'd7, 32'd5);
        send(enc_r(7'b0000000, 5'd4, 5'd5, 3'b001, 5'd12), 1'b1);
        expect_wb(5'd13, 32'h0000_0070, 4'b0000, 4'b0001, 32'd7, 32'd4);
        send(enc_i(12'h004, 5'd5, 3'b001, 5'd13), 1'b1);

        // Write to x0
        expect_wb(5'd0, 32'd9, 4'b0000, 4'b0000, 32'd0, 32'd9);
        send(enc_i(12'd9, 5'd0, 3'b000, 5'd0), 1'b1);
        dbg_addr = 5'd0; #1;
        chk("dbg_x0", dbg_data, 32'd0);

        // Illegal: JAL opcode, R-type funct7 0000001, bad slli funct7
        send(32'h0000_006F, 1'b0);
        send(enc_r(7'b0000001, 5'd5, 5'd4, 3'b000, 5'd6), 1'b0);
        send(enc_i(12'h201, 5'd1, 3'b001, 5'd6), 1'b0);
        check_rf("rf_after_illegal");

        // inst_valid held through ISSUE/WB: accepted exactly once
        w = enc_i(12'd1, 5'd0, 3'b000, 5'd14);
        expect_wb(5'd14, 32'd1, 4'b0000, 4'b0000, 32'd0, 32'd1);
        inst = w; inst_valid = 1'b1;
        @(posedge clk); #1;
        chk("hold_c1_ready", {31'd0, inst_ready}, 32'd0);
        @(posedge clk); #1;
        chk("hold_c2_wb", {31'd0, wb_valid}, 32'd1);
        @(posedge clk); #1;
        inst_valid = 1'b0;
        chk("hold_c3_ready", {31'd0, inst_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_sb_empty", sbq.size(), 32'd0);

        // Reset during ISSUE abandons the instruction
        inst = enc_i(12'd3, 5'd0, 3'b000, 5'd15); inst_valid = 1'b1;
        @(posedge clk); #1;
        inst_valid = 1'b0;
        rst_n = 1'b0;
        chk("rmid_ready_low", {31'd0, inst_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rmid_no_wb", {31'd0, wb_valid}, 32'd0);
        chk("rmid_ready_in_rst", {31'd0, inst_ready}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rmid_ready_after", {31'd0, inst_ready}, 32'd1);
        chk("rmid_no_wb2", {31'd0, wb_valid}, 32'd0);
        for (int i = 0; i < 32; i++) exp_rf[i] = '0;
        check_rf("rf_after_reset");

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drain", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
